// File: rtl/mux_arb_pkg.sv
// Shared types and encodings for the 2:1 wormhole mux arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mux_arb_pkg;

    localparam int NPORT = 2;
    localparam int TYPEW = 2;

    // Flit type field, carried in the top TYPEW bits of each flit.
    localparam logic [TYPEW-1:0] TYPE_NONE = 2'b00;
    localparam logic [TYPEW-1:0] TYPE_HEAD = 2'b01;
    localparam logic [TYPEW-1:0] TYPE_TAIL = 2'b10;
    localparam logic [TYPEW-1:0] TYPE_DATA = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    function automatic logic is_head(input logic [TYPEW-1:0] t);
        return t == TYPE_HEAD;
    endfunction

    function automatic logic is_tail(input logic [TYPEW-1:0] t);
        return t == TYPE_TAIL;
    endfunction

endpackage

// File: rtl/mux_arb_if.sv
// Handshake/status bundle between the two router input ports and the mux arbiter.
// Latency: n/a (wires only).
// Backpressure: oready from downstream gates grant_0/grant_1.
// Ports: ivalid_x/itype_x flit presence and type per input, oready downstream accept,
//        sel one-hot mux select, grant_x per-port consume strobe, busy packet in flight,
//        olen/olen_vld completed-packet length report, err watchdog release pulse.
interface mux_arb_if #(
    parameter int LENW = 8
);
    import mux_arb_pkg::*;

    logic             ivalid_0;
    logic [TYPEW-1:0] itype_0;
    logic             ivalid_1;
    logic [TYPEW-1:0] itype_1;
    logic             oready;
    logic [NPORT-1:0] sel;
    logic             grant_0;
    logic             grant_1;
    logic             busy;
    logic [LENW-1:0]  olen;
    logic             olen_vld;
    logic             err;

    // Arbiter side.
    modport slave (
        input  ivalid_0, itype_0, ivalid_1, itype_1, oready,
        output sel, grant_0, grant_1, busy, olen, olen_vld, err
    );

    // Traffic source / observer side.
    modport master (
        output ivalid_0, itype_0, ivalid_1, itype_1, oready,
        input  sel, grant_0, grant_1, busy, olen, olen_vld, err
    );

endinterface

// File: rtl/mux_arb_rr_pick2.sv
// Combinational 2-input round-robin picker: one-hot gnt from req, ties broken by ptr.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; caller decides when the pick is taken.
// Ports: req request per port, ptr preferred port on a tie, gnt one-hot winner, any some request.
module mux_arb_rr_pick2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt,
    output logic       any
);

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = ptr ? 2'b10 : 2'b01;
        end
    end

    assign any = |req;

endmodule

// File: rtl/mux_arb.sv
// Wormhole arbiter for the 2:1 router output mux: grant held HEAD..TAIL, round-robin between packets.
// Latency: HEAD sampled at an edge drives sel after that edge; one idle bubble after each TAIL.
// Backpressure: oready=0 stalls grants; a stall of TIMEOUT cycles inside a packet forces release with err.
// Ports: clk, rst (async, active high); bus (slave modport) carries flit valid/type in, sel/grant/status out.
module mux_arb
    import mux_arb_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int LENW    = 8
) (
    input  logic     clk,
    input  logic     rst,
    mux_arb_if.slave bus
);

    localparam int              WDW     = $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0]  WD_LAST = WDW'(TIMEOUT - 1);

    state_t           state_q, state_n;
    logic [NPORT-1:0] sel_q, sel_n;
    logic             ptr_q, ptr_n;
    logic [LENW-1:0]  len_q, len_n;
    logic [WDW-1:0]   wd_q, wd_n;
    logic [LENW-1:0]  olen_q, olen_n;
    logic             olen_vld_q, olen_vld_n;
    logic             err_q, err_n;

    logic [1:0]       req;
    logic [1:0]       pick_gnt;
    logic             pick_any;
    logic             gnt0, gnt1;
    logic             xfer, tail_xfer;
    logic [LENW-1:0]  len_inc;

    // Only HEAD flits may open a packet; anything else waiting in IDLE is ignored.
    assign req = {bus.ivalid_1 & is_head(bus.itype_1),
                  bus.ivalid_0 & is_head(bus.itype_0)};

    mux_arb_rr_pick2 u_pick (
        .req (req),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .any (pick_any)
    );

    // Saturating flit count; the reported length includes the current (last) transfer.
    assign len_inc = (len_q == '1) ? len_q : len_q + 1'b1;

    always_comb begin
        state_n    = state_q;
        sel_n      = sel_q;
        ptr_n      = ptr_q;
        len_n      = len_q;
        wd_n       = wd_q;
        olen_n     = olen_q;
        olen_vld_n = 1'b0;
        err_n      = 1'b0;
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        xfer       = 1'b0;
        tail_xfer  = 1'b0;

        if (state_q == ST_IDLE) begin
            if (pick_any) begin
                sel_n   = pick_gnt;
                state_n = ST_BUSY;
                len_n   = '0;
                wd_n    = '0;
            end
        end else begin
            // A HEAD on the owning port mid-packet is just another flit here.
            gnt0      = sel_q[0] & bus.ivalid_0 & bus.oready;
            gnt1      = sel_q[1] & bus.ivalid_1 & bus.oready;
            xfer      = gnt0 | gnt1;
            tail_xfer = (gnt0 & is_tail(bus.itype_0)) | (gnt1 & is_tail(bus.itype_1));

            if (xfer) begin
                len_n = len_inc;
                wd_n  = '0;
                if (tail_xfer) begin
                    olen_n     = len_inc;
                    olen_vld_n = 1'b1;
                    sel_n      = '0;
                    state_n    = ST_IDLE;
                    // Prefer the port that did not just own the output.
                    ptr_n      = sel_q[0];
                end
            end else if (wd_q == WD_LAST) begin
                // Stalled packet: abandon it without touching the length report.
                err_n   = 1'b1;
                sel_n   = '0;
                state_n = ST_IDLE;
                ptr_n   = sel_q[0];
            end else begin
                wd_n = wd_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            sel_q      <= '0;
            ptr_q      <= 1'b0;
            len_q      <= '0;
            wd_q       <= '0;
            olen_q     <= '0;
            olen_vld_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_n;
            sel_q      <= sel_n;
            ptr_q      <= ptr_n;
            len_q      <= len_n;
            wd_q       <= wd_n;
            olen_q     <= olen_n;
            olen_vld_q <= olen_vld_n;
            err_q      <= err_n;
        end
    end

    assign bus.sel      = sel_q;
    assign bus.grant_0  = gnt0;
    assign bus.grant_1  = gnt1;
    assign bus.busy     = (state_q == ST_BUSY);
    assign bus.olen     = olen_q;
    assign bus.olen_vld = olen_vld_q;
    assign bus.err      = err_q;

endmodule
